// File: rtl/run_ctrl.sv
// run_ctrl: sequences one test run of a CPU under test.
//   IDLE -> RST (cpu_reset held for RST_CYCLES) -> RUN -> DONE.
//   A run ends on abort, on a halt (HALT_REPEAT consecutive valid cycles at the
//   same PC after it was first seen), or after TIMEOUT RUN cycles. The cause is
//   latched in done / timed_out / aborted and held until the next start.
// Ports:
//   clk, reset (async, active-low)       clock and block reset
//   start, abort                         run control requests
//   pc_valid, pc_i[31:0]                 CPU program-counter observation
//   cpu_reset                            registered active-high reset to the CPU
//   running                              high in RUN
//   done, timed_out, aborted             end-of-run cause, valid in DONE
//   cycle_cnt[CNT_W-1:0]                 RUN cycles of the current/last run
//   halt_pc[31:0]                        PC that caused the halt
module run_ctrl #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned HALT_REPEAT = 8,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pc_valid,
  input  logic [31:0]      pc_i,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timed_out,
  output logic             aborted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [31:0]      halt_pc
);

  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
  localparam int unsigned RepW = $clog2(HALT_REPEAT);

  typedef enum logic [1:0] {StIdle, StRst, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [RstW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [RepW-1:0]    rep_cnt_q, rep_cnt_d;
  logic [31:0]        last_pc_q, last_pc_d;
  logic               last_vld_q, last_vld_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [31:0]        halt_pc_q, halt_pc_d;
  logic               done_q, done_d;
  logic               timed_out_q, timed_out_d;
  logic               aborted_q, aborted_d;
  logic               cpu_reset_q, cpu_reset_d;

  logic pc_match, halt_hit, tmo_hit;

  // last_vld_q keeps the first valid PC of a run from matching the cleared last_pc_q.
  assign pc_match = pc_valid && last_vld_q && (pc_i == last_pc_q);
  assign halt_hit = pc_match && (rep_cnt_q == RepW'(HALT_REPEAT - 1));
  assign tmo_hit  = (cycle_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    last_pc_d   = last_pc_q;
    last_vld_d  = last_vld_q;
    cycle_cnt_d = cycle_cnt_q;
    halt_pc_d   = halt_pc_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    aborted_d   = aborted_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRst;
          rst_cnt_d   = '0;
          rep_cnt_d   = '0;
          last_pc_d   = '0;
          last_vld_d  = 1'b0;
          cycle_cnt_d = '0;
          halt_pc_d   = '0;
          done_d      = 1'b0;
          timed_out_d = 1'b0;
          aborted_d   = 1'b0;
        end
      end
      StRst: begin
        if (abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StRun: begin
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (pc_valid) begin
          if (pc_match) begin
            // On a halt the counter is left alone so it cannot wrap.
            if (!halt_hit) rep_cnt_d = rep_cnt_q + RepW'(1);
          end else begin
            rep_cnt_d  = '0;
            last_pc_d  = pc_i;
            last_vld_d = 1'b1;
          end
        end
        if (abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else if (halt_hit) begin
          state_d   = StDone;
          done_d    = 1'b1;
          halt_pc_d = pc_i;
        end else if (tmo_hit) begin
          state_d     = StDone;
          timed_out_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered from the next state so cpu_reset is glitch-free and aligned with RST.
    cpu_reset_d = (state_d == StRst);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      last_pc_q   <= '0;
      last_vld_q  <= 1'b0;
      cycle_cnt_q <= '0;
      halt_pc_q   <= '0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      last_pc_q   <= last_pc_d;
      last_vld_q  <= last_vld_d;
      cycle_cnt_q <= cycle_cnt_d;
      halt_pc_q   <= halt_pc_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      aborted_q   <= aborted_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign running   = (state_q == StRun);
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign aborted   = aborted_q;
  assign cycle_cnt = cycle_cnt_q;
  assign halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl: directed scenarios plus randomized runs, each run's
// outcome predicted by a run-level reference model over the stimulus arrays.
module tb_run_ctrl;

  localparam int unsigned RstCycles  = 4;
  localparam int unsigned HaltRepeat = 8;
  localparam int unsigned Timeout    = 20;
  localparam int unsigned CntW       = 32;
  localparam int MaxLen = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            pc_valid = 1'b0;
  logic [31:0]     pc_i = '0;
  logic            cpu_reset, running, done, timed_out, aborted;
  logic [CntW-1:0] cycle_cnt;
  logic [31:0]     halt_pc;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus for one run, indexed by RUN cycle.
  logic        vld [MaxLen];
  logic [31:0] pcs [MaxLen];
  int          abort_at;

  // Predicted outcome of the run.
  int          exp_len;
  logic        exp_done, exp_tmo, exp_abt;
  logic [31:0] exp_halt;

  run_ctrl #(
    .RST_CYCLES (RstCycles),
    .HALT_REPEAT(HaltRepeat),
    .TIMEOUT    (Timeout),
    .CNT_W      (CntW)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .pc_valid (pc_valid),
    .pc_i     (pc_i),
    .cpu_reset(cpu_reset),
    .running  (running),
    .done     (done),
    .timed_out(timed_out),
    .aborted  (aborted),
    .cycle_cnt(cycle_cnt),
    .halt_pc  (halt_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Walk the run cycle by cycle: abort wins, then a halt once the PC has been
  // seen HaltRepeat more times in a row (invalid cycles skipped), then timeout.
  task automatic compute_expected();
    int          same;
    bit          seen;
    logic [31:0] last;
    same = 0; seen = 0; last = '0;
    exp_done = 0; exp_tmo = 0; exp_abt = 0; exp_halt = '0; exp_len = Timeout;
    for (int k = 0; k < int'(Timeout); k++) begin
      if (abort_at == k) begin
        exp_abt = 1; exp_len = k + 1; return;
      end
      if (vld[k]) begin
        if (seen && pcs[k] == last) begin
          same++;
          if (same == int'(HaltRepeat)) begin
            exp_done = 1; exp_halt = pcs[k]; exp_len = k + 1; return;
          end
        end else begin
          seen = 1; last = pcs[k]; same = 0;
        end
      end
    end
    exp_tmo = 1;
  endtask

  task automatic check_result(input string name);
    check_eq({name, ":cycle_cnt"}, cycle_cnt, exp_len);
    check_eq({name, ":flags"}, {29'd0, done, timed_out, aborted}, {29'd0, exp_done, exp_tmo, exp_abt});
    check_eq({name, ":halt_pc"}, halt_pc, exp_halt);
    check_eq({name, ":running"}, running, 0);
    check_eq({name, ":cpu_reset"}, cpu_reset, 0);
  endtask

  // Starts from IDLE or DONE, runs the stored stimulus, checks the outcome and
  // that DONE holds it against abort and PC activity.
  task automatic do_run(input string name);
    int n;
    int k;
    compute_expected();
    @(negedge clk); start = 1; abort = 0; pc_valid = 0;
    @(negedge clk); start = 0;
    check_eq({name, ":rst_entry_cpu_reset"}, cpu_reset, 1);
    check_eq({name, ":rst_entry_clear"}, {done, timed_out, aborted}, 0);
    check_eq({name, ":rst_entry_cnt"}, cycle_cnt | halt_pc, 0);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      pc_valid = 1'($urandom_range(0, 1));
      pc_i = $urandom;
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!cpu_reset) break;
      n++;
    end
    start = 0;
    check_eq({name, ":rst_len"}, n, RstCycles);
    check_eq({name, ":run_entry"}, running, 1);
    k = 0;
    while (k < MaxLen) begin
      pc_valid = vld[k];
      pc_i = pcs[k];
      abort = (k == abort_at);
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
      if (!running) break;
    end
    start = 0; abort = 0; pc_valid = 0;
    check_eq({name, ":run_len"}, k, exp_len);
    check_result(name);
    repeat (3) begin
      abort = 1; pc_valid = 1; pc_i = $urandom;
      @(negedge clk);
    end
    abort = 0; pc_valid = 0;
    check_result({name, "_hold"});
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MaxLen; k++) begin
      vld[k] = 1'b1;
      pcs[k] = 32'h1000 + 32'(k * 4);
    end
    abort_at = -1;
  endtask

  initial begin
    // Reset: create a real falling edge so the asynchronous reset fires.
    #1 reset = 0;
    #1;
    check_eq("reset_cpu_reset", cpu_reset, 1);
    check_eq("reset_running", running, 0);
    check_eq("reset_flags", {done, timed_out, aborted}, 0);
    check_eq("reset_cnt", cycle_cnt, 0);
    check_eq("reset_halt_pc", halt_pc, 0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_eq("idle_cpu_reset", cpu_reset, 0);
    abort = 1;
    @(negedge clk); @(negedge clk);
    abort = 0;
    check_eq("idle_abort_ignored", {running, cpu_reset, done, timed_out, aborted}, 0);

    // PC walks 0x3000..0x3010 then sticks: halt on the 8th repeat.
    clear_stim();
    for (int k = 0; k < MaxLen; k++) pcs[k] = (k < 4) ? 32'h3000 + 32'(k * 4) : 32'h3010;
    do_run("stick_3010");
    check_eq("stick_3010_halt_pc", halt_pc, 32'h3010);

    // Always-changing PC times out; repeated from DONE.
    clear_stim();
    do_run("timeout1");
    check_eq("timeout1_cnt_abs", cycle_cnt, Timeout);
    do_run("timeout2");

    // Halt lands on the cycle where cycle_cnt is Timeout-1, then with abort too.
    clear_stim();
    for (int k = 11; k < MaxLen; k++) pcs[k] = 32'h5550;
    do_run("halt_vs_tmo");
    abort_at = Timeout - 1;
    do_run("abort_vs_halt");

    // First valid PC of zero must not match the cleared last-PC register.
    clear_stim();
    for (int k = 0; k < MaxLen; k++) pcs[k] = 32'h0;
    do_run("pc_zero");

    // pc_valid toggling with a constant PC.
    clear_stim();
    for (int k = 0; k < MaxLen; k++) begin
      vld[k] = (k % 2 == 0);
      pcs[k] = (k % 2 == 0) ? 32'h40 : 32'($urandom);
    end
    do_run("valid_toggle");

    // Abort while still in RST.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; abort = 1;
    @(negedge clk); abort = 0;
    check_eq("rst_abort_flags", {done, timed_out, aborted}, 3'b001);
    check_eq("rst_abort_cnt", cycle_cnt, 0);
    check_eq("rst_abort_state", {running, cpu_reset}, 0);

    // Reset in the middle of RUN, then a clean run.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (RstCycles + 5) begin
      pc_valid = 1; pc_i = 32'h77;
      @(negedge clk);
    end
    check_eq("midrun_running", running, 1);
    reset = 0;
    #1;
    check_eq("midrun_async", {cpu_reset, running, done, timed_out, aborted}, 5'b10000);
    check_eq("midrun_async_cnt", cycle_cnt | halt_pc, 0);
    @(negedge clk);
    reset = 1; pc_valid = 0;
    @(negedge clk);
    check_eq("midrun_release", {cpu_reset, running, done, timed_out, aborted}, 0);
    clear_stim();
    for (int k = 2; k < MaxLen; k++) pcs[k] = 32'h88;
    do_run("after_reset");

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < MaxLen; k++) begin
        vld[k] = ($urandom_range(0, 7) != 0);
        if (k == 0 || $urandom_range(0, 5) == 0) pcs[k] = 32'($urandom_range(0, 2)) << 2;
        else pcs[k] = pcs[k - 1];
      end
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 25)) : -1;
      do_run($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
